// File: rtl/hack_ram_sync.sv
// Hack data RAM: single port, valid/ready requests, one-cycle held read response.
// Define HACK_RAM_CLEAR_EN to zero the whole array after reset before serving requests.
module hack_ram_sync #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16384,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic             run;
    logic             accept;
    logic             rd_acc;
    logic             wr_acc;
    logic             in_range;
    logic [IDX_W-1:0] idx;

`ifdef HACK_RAM_CLEAR_EN
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] cnt_d;
    logic             clr_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        unique case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign run = (state_q == RUN);
`else
    logic run_q;

    // No clear pass: serving starts one edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign run = run_q;
`endif

    assign init_done = run;
    assign req_ready = run && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign rd_acc    = accept && !req_we;
    assign wr_acc    = accept && req_we;
    assign in_range  = ({1'b0, req_addr} < DEPTH_X);
    assign idx       = req_addr[IDX_W-1:0];

    // Array has no reset; only the clear pass (if built) initialises it.
    always_ff @(posedge clk) begin
`ifdef HACK_RAM_CLEAR_EN
        if (clr_we) begin
            mem[cnt_q] <= '0;
        end else if (wr_acc && in_range) begin
            mem[idx] <= req_wdata;
        end
`else
        if (wr_acc && in_range) begin
            mem[idx] <= req_wdata;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else if (rd_acc) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= in_range ? mem[idx] : '0;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
